// File: rtl/uart_mmio_pkg.sv
// Shared constants for the UART MMIO controller: register offsets, status bit
// positions and the TX sequencer state type.
package uart_mmio_pkg;

    localparam logic [7:0] UART_ADDR_TXD  = 8'h18;
    localparam logic [7:0] UART_ADDR_RXD  = 8'h1C;
    localparam logic [7:0] UART_ADDR_STAT = 8'h20;

    localparam int STAT_TX_FULL  = 4;
    localparam int STAT_RX_AVAIL = 3;
    localparam int STAT_TX_DONE  = 2;
    localparam int STAT_TX_IDLE  = 1;
    localparam int STAT_OVR      = 0;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; pointers carry an extra wrap bit
// so every entry is usable. A push on a full FIFO is accepted when a pop happens too.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX/RX FIFOs, TX sequencer and TXD/RXD/STATUS registers.
// Optional feature macro UART_OVR_EN: RX overrun flag plus saturating drop counter at ADDR_STAT+4.
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int         TX_DEPTH  = 8,
    parameter int         RX_DEPTH  = 8,
    parameter logic [7:0] ADDR_TXD  = UART_ADDR_TXD,
    parameter logic [7:0] ADDR_RXD  = UART_ADDR_RXD,
    parameter logic [7:0] ADDR_STAT = UART_ADDR_STAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [7:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_active,
    input  logic        tx_done,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte
);

    logic        wr_txd;
    logic        rd_rxd;
    logic        rd_stat;
    logic        tx_push;
    logic        tx_pop;
    logic        tx_full;
    logic        tx_empty;
    logic [7:0]  tx_head;
    logic        rx_pop;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic        done_accept;
    logic        done_flag_reg;
    logic        ovr;
    logic [31:0] status;
    tx_state_t   state_reg;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    assign wr_txd  = sel && we && (addr == ADDR_TXD);
    assign rd_rxd  = sel && re && (addr == ADDR_RXD);
    assign rd_stat = sel && re && (addr == ADDR_STAT);

    // The sequencer pops only when the serializer is free, so tx_byte never changes mid-frame.
    assign tx_push     = wr_txd && !tx_full;
    assign tx_pop      = (state_reg == IDLE) && !tx_empty && !tx_active;
    assign done_accept = (state_reg == WAIT) && tx_done;
    assign rx_pop      = rd_rxd && !rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_dv),
        .pop   (rx_pop),
        .din   (rx_byte),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            tx_dv     <= 1'b0;
            tx_byte   <= 8'h00;
        end else begin
            tx_dv <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tx_pop) begin
                        tx_byte   <= tx_head;
                        tx_dv     <= 1'b1;
                        state_reg <= LAUNCH;
                    end
                end
                LAUNCH:  state_reg <= WAIT;
                WAIT:    if (tx_done) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Set wins over the read-clear so a completion coinciding with a STATUS read is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_flag_reg <= 1'b0;
        end else if (done_accept) begin
            done_flag_reg <= 1'b1;
        end else if (rd_stat) begin
            done_flag_reg <= 1'b0;
        end
    end

`ifdef UART_OVR_EN
    logic       rx_drop;
    logic       rd_cnt;
    logic       ovr_reg;
    logic [7:0] drop_cnt_reg;

    assign rx_drop = rx_dv && rx_full && !rx_pop;
    assign rd_cnt  = sel && re && (addr == ADDR_STAT + 8'd4);
    assign ovr     = ovr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_reg      <= 1'b0;
            drop_cnt_reg <= 8'h00;
        end else begin
            if (rx_drop) begin
                ovr_reg <= 1'b1;
            end else if (rd_stat) begin
                ovr_reg <= 1'b0;
            end
            if (rd_cnt) begin
                drop_cnt_reg <= {7'b0, rx_drop};
            end else if (rx_drop && drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end
`else
    assign ovr = 1'b0;
`endif

    always_comb begin
        status                = '0;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_RX_AVAIL] = !rx_empty;
        status[STAT_TX_DONE]  = done_flag_reg;
        status[STAT_TX_IDLE]  = tx_empty && (state_reg == IDLE);
        status[STAT_OVR]      = ovr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_rxd) begin
            rdata <= {24'b0, rx_empty ? 8'h00 : rx_head};
        end else if (rd_stat) begin
            rdata <= status;
        end
`ifdef UART_OVR_EN
        else if (rd_cnt) begin
            rdata <= {24'b0, drop_cnt_reg};
        end
`endif
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Randomized self-checking bench for uart_mmio_ctrl against a queue-based model.
module tb_uart_mmio_ctrl;

    localparam int DEPTH = 8;
    localparam logic [7:0] A_TXD  = 8'h18;
    localparam logic [7:0] A_RXD  = 8'h1C;
    localparam logic [7:0] A_STAT = 8'h20;
    localparam logic [7:0] A_CNT  = 8'h24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wdata = '0;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [31:0] rdata;
    logic        tx_dv;
    logic [7:0]  tx_byte;

    int tests = 0;
    int fails = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         m_flag = 0;
    bit         m_ovr = 0;
    int         m_cnt = 0;

    uart_mmio_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .addr      (addr),
        .we        (we),
        .re        (re),
        .wdata     (wdata),
        .rdata     (rdata),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_status(input bit fsm_idle);
        logic [31:0] s;
        s    = '0;
        s[4] = (txq.size() == DEPTH);
        s[3] = (rxq.size() != 0);
        s[2] = m_flag;
        s[1] = (txq.size() == 0) && fsm_idle;
        s[0] = m_ovr;
        return s;
    endfunction

    task automatic mmio_write(input logic [7:0] a, input logic [31:0] d);
        sel = 1; we = 1; addr = a; wdata = d;
        step();
        sel = 0; we = 0; wdata = $urandom;
        if (a == A_TXD && txq.size() < DEPTH) txq.push_back(d[7:0]);
        $display("[TB] write addr=%02h data=%08h", a, d);
    endtask

    task automatic mmio_read(input logic [7:0] a, input logic done_too);
        sel = 1; re = 1; addr = a; tx_done = done_too;
        step();
        sel = 0; re = 0; tx_done = 0;
        if (a == A_STAT) begin
            m_flag = done_too;
            m_ovr  = 0;
        end
        if (a == A_RXD && rxq.size() != 0) void'(rxq.pop_front());
`ifdef UART_OVR_EN
        if (a == A_CNT) m_cnt = 0;
`endif
        $display("[TB] read  addr=%02h rdata=%08h", a, rdata);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_dv = 1; rx_byte = b;
        step();
        rx_dv = 0;
        if (rxq.size() < DEPTH) begin
            rxq.push_back(b);
        end else begin
`ifdef UART_OVR_EN
            m_ovr = 1;
            if (m_cnt < 255) m_cnt++;
`endif
        end
        $display("[TB] rx_dv byte=%02h", b);
    endtask

    // Plays the role of uart_tx for n bytes: checks order, pulse width, hold and gap.
    task automatic serve(input int n);
        int c;
        logic [7:0] held;
        for (int i = 0; i < n; i++) begin
            c = 0;
            while (tx_dv !== 1'b1 && c < 60) begin
                step();
                c++;
            end
            tests++;
            if (tx_dv !== 1'b1) begin
                fails++;
                $display("FAIL serve_timeout: tx_dv=%b required 1 within 60 cycles", tx_dv);
                return;
            end
            held = txq.pop_front();
            tests++;
            if (tx_byte !== held) begin
                fails++;
                $display("FAIL tx_order: tx_byte=%02h required %02h", tx_byte, held);
            end
            if (i > 0) begin
                tests++;
                if (c + 1 < 2) begin
                    fails++;
                    $display("FAIL tx_gap: gap=%0d required >=2", c + 1);
                end
            end
            $display("[TB] tx_dv byte=%02h gap=%0d", tx_byte, c + 1);
            step();
            tests++;
            if (tx_dv !== 1'b0) begin
                fails++;
                $display("FAIL tx_dv_width: tx_dv=%b required 0", tx_dv);
            end
            repeat ($urandom_range(3, 0)) step();
            tests++;
            if (tx_byte !== held) begin
                fails++;
                $display("FAIL tx_hold: tx_byte=%02h required %02h", tx_byte, held);
            end
            tx_done = 1;
            step();
            tx_done = 0;
            m_flag = 1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1;
        repeat (3) step();
        reset = 0;
        step();
        tests++;
        if (rdata !== 32'h0 || tx_dv !== 1'b0 || tx_byte !== 8'h00) begin
            fails++;
            $display("FAIL reset_values: rdata=%08h tx_dv=%b tx_byte=%02h required 0/0/0", rdata, tx_dv, tx_byte);
        end
        tx_done = 1; step(); tx_done = 0;
        mmio_write(A_RXD, 32'h77);
        mmio_write(A_STAT, 32'hFF);
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== 32'h02 || rdata !== e) begin
            fails++;
            $display("FAIL reset_status: rdata=%08h required %08h", rdata, e);
        end
        mmio_read(8'h00, 0);
        tests++;
        if (rdata !== e) begin
            fails++;
            $display("FAIL unmapped_read: rdata=%08h required %08h", rdata, e);
        end
    endtask

    task automatic test_tx_latency();
        logic [7:0] b;
        b = 8'($urandom);
        tx_active = 0;
        mmio_write(A_TXD, {24'h0, b});
        tests++;
        if (tx_dv !== 1'b0) begin
            fails++;
            $display("FAIL tx_latency_n1: tx_dv=%b required 0", tx_dv);
        end
        step();
        tests++;
        if (tx_dv !== 1'b1 || tx_byte !== b) begin
            fails++;
            $display("FAIL tx_latency_n2: tx_dv=%b tx_byte=%02h required 1/%02h", tx_dv, tx_byte, b);
        end
        serve(1);
        mmio_read(A_STAT, 0);
    endtask

    task automatic test_tx_order(input bit fixed);
        int n;
        logic [31:0] e;
        tx_active = 1;
        if (fixed) begin
            mmio_write(A_TXD, 32'h41);
            mmio_write(A_TXD, 32'h42);
            mmio_write(A_TXD, 32'h43);
        end
        n = $urandom_range(5, 1);
        for (int i = 0; i < n; i++) mmio_write(A_TXD, $urandom);
        step();
        tests++;
        if (tx_dv !== 1'b0) begin
            fails++;
            $display("FAIL tx_stall: tx_dv=%b required 0 while tx_active", tx_dv);
        end
        tx_active = 0;
        serve(txq.size());
        repeat (4) step();
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== e) begin
            fails++;
            $display("FAIL tx_order_status: rdata=%08h required %08h", rdata, e);
        end
    endtask

    task automatic test_tx_full();
        logic [31:0] e;
        int seen;
        tx_active = 1;
        for (int i = 0; i < DEPTH - 1; i++) mmio_write(A_TXD, $urandom);
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== e || rdata[4] !== 1'b0) begin
            fails++;
            $display("FAIL tx_not_full: rdata=%08h required %08h", rdata, e);
        end
        mmio_write(A_TXD, $urandom);
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== e || rdata[4] !== 1'b1) begin
            fails++;
            $display("FAIL tx_full: rdata=%08h required %08h", rdata, e);
        end
        mmio_write(A_TXD, 32'hEE);
        tx_active = 0;
        serve(DEPTH);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_dv === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL tx_ninth_dropped: extra tx_dv pulses=%0d required 0", seen);
        end
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== e) begin
            fails++;
            $display("FAIL tx_full_drained: rdata=%08h required %08h", rdata, e);
        end
    endtask

    task automatic test_rx();
        int n;
        logic [31:0] e;
        rx_push(8'h5A);
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== e || rdata[3] !== 1'b1) begin
            fails++;
            $display("FAIL rx_avail: rdata=%08h required %08h", rdata, e);
        end
        rx_push(8'hA5);
        n = $urandom_range(4, 0);
        for (int i = 0; i < n; i++) rx_push(8'($urandom));
        while (rxq.size() != 0) begin
            e = {24'h0, rxq[0]};
            mmio_read(A_RXD, 0);
            tests++;
            if (rdata !== e) begin
                fails++;
                $display("FAIL rx_data: rdata=%08h required %08h", rdata, e);
            end
        end
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== e || rdata[3] !== 1'b0) begin
            fails++;
            $display("FAIL rx_empty_status: rdata=%08h required %08h", rdata, e);
        end
        mmio_read(A_RXD, 0);
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL rx_empty_read: rdata=%08h required 00000000", rdata);
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] e;
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) rx_push(8'($urandom));
        b = 8'($urandom);
        e = {24'h0, rxq[0]};
        rx_dv = 1; rx_byte = b; sel = 1; re = 1; addr = A_RXD;
        step();
        rx_dv = 0; sel = 0; re = 0;
        void'(rxq.pop_front());
        rxq.push_back(b);
        $display("[TB] read  addr=%02h with rx_dv byte=%02h rdata=%08h", A_RXD, b, rdata);
        tests++;
        if (rdata !== e) begin
            fails++;
            $display("FAIL rx_pop_push_full: rdata=%08h required %08h", rdata, e);
        end
        rx_push(8'($urandom));
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== e) begin
            fails++;
            $display("FAIL rx_ovr_status: rdata=%08h required %08h", rdata, e);
        end
`ifdef UART_OVR_EN
        e = m_cnt;
        mmio_read(A_CNT, 0);
        tests++;
        if (rdata !== e || rdata !== 32'h1) begin
            fails++;
            $display("FAIL drop_count: rdata=%08h required %08h", rdata, e);
        end
        mmio_read(A_CNT, 0);
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL drop_count_clear: rdata=%08h required 00000000", rdata);
        end
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== e || rdata[0] !== 1'b0) begin
            fails++;
            $display("FAIL ovr_clear: rdata=%08h required %08h", rdata, e);
        end
`else
        mmio_read(A_CNT, 0);
        tests++;
        if (rdata !== e) begin
            fails++;
            $display("FAIL cnt_unmapped: rdata=%08h required %08h", rdata, e);
        end
`endif
        while (rxq.size() != 0) begin
            e = {24'h0, rxq[0]};
            mmio_read(A_RXD, 0);
            tests++;
            if (rdata !== e) begin
                fails++;
                $display("FAIL rx_drain: rdata=%08h required %08h", rdata, e);
            end
        end
    endtask

    task automatic test_done_collision();
        logic [31:0] e;
        int c;
        tx_active = 0;
        mmio_write(A_TXD, $urandom);
        c = 0;
        while (tx_dv !== 1'b1 && c < 20) begin
            step();
            c++;
        end
        tests++;
        if (tx_dv !== 1'b1 || tx_byte !== txq[0]) begin
            fails++;
            $display("FAIL collide_launch: tx_dv=%b tx_byte=%02h required 1/%02h", tx_dv, tx_byte, txq[0]);
        end
        void'(txq.pop_front());
        repeat (2) step();
        e = exp_status(0);
        mmio_read(A_STAT, 1);
        tests++;
        if (rdata !== e || rdata[2] !== 1'b0) begin
            fails++;
            $display("FAIL collide_read1: rdata=%08h required %08h", rdata, e);
        end
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== e || rdata[2] !== 1'b1) begin
            fails++;
            $display("FAIL collide_read2: rdata=%08h required %08h", rdata, e);
        end
        e = exp_status(1);
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== e || rdata[2] !== 1'b0) begin
            fails++;
            $display("FAIL collide_read3: rdata=%08h required %08h", rdata, e);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        int seen;
        tx_active = 1;
        for (int i = 0; i < 4; i++) mmio_write(A_TXD, $urandom);
        tx_active = 0;
        c = 0;
        while (tx_dv !== 1'b1 && c < 20) begin
            step();
            c++;
        end
        tests++;
        if (tx_dv !== 1'b1) begin
            fails++;
            $display("FAIL midreset_launch: tx_dv=%b required 1", tx_dv);
        end
        repeat (2) step();
        reset = 1;
        step();
        reset = 0;
        txq.delete(); rxq.delete();
        m_flag = 0; m_ovr = 0; m_cnt = 0;
        $display("[TB] reset pulse in WAIT");
        tests++;
        if (rdata !== 32'h0 || tx_dv !== 1'b0) begin
            fails++;
            $display("FAIL midreset_values: rdata=%08h tx_dv=%b required 0/0", rdata, tx_dv);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_dv === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL midreset_no_tx: tx_dv pulses=%0d required 0", seen);
        end
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== 32'h02) begin
            fails++;
            $display("FAIL midreset_status: rdata=%08h required 00000002", rdata);
        end
        tx_done = 1; step(); tx_done = 0;
        mmio_read(A_STAT, 0);
        tests++;
        if (rdata !== 32'h02) begin
            fails++;
            $display("FAIL late_done: rdata=%08h required 00000002", rdata);
        end
    endtask

    initial begin
        test_reset();
        test_tx_latency();
        test_tx_order(1);
        for (int r = 0; r < 3; r++) test_tx_order(0);
        test_tx_full();
        test_rx();
        test_rx_overflow();
        test_done_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
